// File: rtl/bcd_binary_encoder_pkg.sv
// Shared definitions for the BCD-to-binary encoder.
//   - FSM state encoding (2'd3 is unused and treated as IDLE by the top).
//   - BCD digit geometry and the reverse double-dabble adjust constants.
//   - adjust_digit(): the per-digit correction applied after every right shift.
package bcd_binary_encoder_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam logic [3:0] ADJ_THRESH  = 4'd8;
    localparam logic [3:0] ADJ_SUB     = 4'd3;

    // A digit that reads >= 8 after the shift received a carried-in tens
    // bit worth 8 that should have been worth 5; taking 3 away restores it.
    function automatic logic [3:0] adjust_digit(input logic [3:0] digit);
        return (digit >= ADJ_THRESH) ? digit - ADJ_SUB : digit;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Combinational correction of one 4-bit BCD digit during reverse double-dabble.
// Ports:
//   digit    - digit value straight after the work-register shift
//   adjusted - digit - 3 when digit >= 8, otherwise digit unchanged
module bcd_digit_adjust
    import bcd_binary_encoder_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    assign adjusted = adjust_digit(digit);

endmodule

// File: rtl/bcd_binary_encoder.sv
// Sequential BCD-to-binary encoder using reverse double-dabble, one
// shift/adjust iteration per clock.
// Ports:
//   clk           - clock, all state changes on the rising edge
//   reset         - synchronous active-high reset
//   start         - conversion request, only looked at while idle
//   BCD_Input     - packed BCD, digit 0 in bits [3:0] (least significant)
//   Binary_Output - registered result, held until the next done
//   busy          - high whenever the encoder is not idle
//   done          - one-cycle pulse; Binary_Output and error valid here
//   error         - invalid digit (> 9) or value too large for WORD_LENGTH bits
module bcd_binary_encoder
    import bcd_binary_encoder_pkg::*;
#(
    parameter int WORD_LENGTH = 7,
    parameter int DIGITS      = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [BCD_DIGIT_W*DIGITS-1:0]   BCD_Input,
    output logic [WORD_LENGTH-1:0]          Binary_Output,
    output logic                            busy,
    output logic                            done,
    output logic                            error
);

    localparam int BCD_W  = BCD_DIGIT_W * DIGITS;
    localparam int WORK_W = BCD_W + WORD_LENGTH;
    localparam int CNT_W  = $clog2(WORD_LENGTH + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WORD_LENGTH - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  count;
    // {bcd digits, binary result}; bits migrate from the BCD half into the
    // binary half one position per iteration.
    logic [WORK_W-1:0] work;
    logic [WORK_W-1:0] shifted;
    logic [WORK_W-1:0] adjusted;
    logic              digits_ok;

    always_comb begin
        digits_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (BCD_Input[BCD_DIGIT_W*i +: BCD_DIGIT_W] > BCD_MAX) begin
                digits_ok = 1'b0;
            end
        end
    end

    assign shifted = work >> 1;
    assign adjusted[WORD_LENGTH-1:0] = shifted[WORD_LENGTH-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
        bcd_digit_adjust u_adjust (
            .digit    (shifted [WORD_LENGTH + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .adjusted (adjusted[WORD_LENGTH + BCD_DIGIT_W*g +: BCD_DIGIT_W])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            work          <= '0;
            Binary_Output <= '0;
            error         <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    work  <= adjusted;
                    count <= count + 1'b1;
                    if (count == LAST_COUNT) begin
                        Binary_Output <= adjusted[WORD_LENGTH-1:0];
                        // Anything left in the BCD half is value >= 2**WORD_LENGTH.
                        error         <= |adjusted[WORK_W-1:WORD_LENGTH];
                        state         <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    // IDLE, and the unused encoding 2'd3 behaves the same.
                    state <= IDLE;
                    if (start) begin
                        if (digits_ok) begin
                            work  <= {BCD_Input, {WORD_LENGTH{1'b0}}};
                            count <= '0;
                            state <= SHIFT;
                        end else begin
                            Binary_Output <= '0;
                            error         <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
            endcase
        end
    end

    assign busy = (state == SHIFT) || (state == DONE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_binary_encoder.sv
// Self-checking bench for bcd_binary_encoder: a 2-digit/7-bit instance for
// most scenarios and a 3-digit/7-bit instance for the overflow cases.
// Expected results come from an arithmetic model (decimal value, mod 2**7).
module tb_bcd_binary_encoder;

    localparam int WL = 7;

    typedef struct packed {
        logic          e;
        logic [WL-1:0] o;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, start3;
    logic [7:0]    bcd;
    logic [11:0]   bcd3;
    logic [WL-1:0] bo, bo3;
    logic          busy, done, err;
    logic          busy3, done3, err3;

    int total = 0;
    int bad   = 0;

    exp_t          q[$];
    exp_t          q3[$];
    logic [WL-1:0] hold_o, hold_o3;
    logic          hold_e, hold_e3;

    always #5 clk = ~clk;

    bcd_binary_encoder #(.WORD_LENGTH(WL), .DIGITS(2)) dut (
        .clk(clk), .reset(reset), .start(start), .BCD_Input(bcd),
        .Binary_Output(bo), .busy(busy), .done(done), .error(err)
    );

    bcd_binary_encoder #(.WORD_LENGTH(WL), .DIGITS(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .BCD_Input(bcd3),
        .Binary_Output(bo3), .busy(busy3), .done(done3), .error(err3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decimal value of nd packed BCD digits; invalid digit -> 0 with error,
    // otherwise low WL bits with error when the value does not fit.
    task automatic model(input logic [11:0] v, input int nd,
                         output logic [WL-1:0] o, output logic e);
        int  val;
        int  d;
        bit  bad_digit;
        val = 0;
        bad_digit = 0;
        for (int i = nd - 1; i >= 0; i--) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) bad_digit = 1;
            val = val * 10 + d;
        end
        if (bad_digit) begin
            o = '0;
            e = 1'b1;
        end else begin
            o = WL'(val % (1 << WL));
            e = (val >= (1 << WL));
        end
    endtask

    // Model-side reset: pending expectations are dropped and outputs clear.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            q3.delete();
            hold_o  = '0;
            hold_e  = 1'b0;
            hold_o3 = '0;
            hold_e3 = 1'b0;
        end
    end

    // Every cycle: a done must match the oldest pending expectation, and
    // outside done the outputs must hold their last value.
    always @(negedge clk) begin
        exp_t x;
        if (done !== 1'b0) begin
            if (q.size() == 0) chk("spurious_done", 1, 0);
            else begin
                x = q.pop_front();
                chk("result", bo, x.o);
                chk("error", err, x.e);
                hold_o = x.o;
                hold_e = x.e;
            end
        end else begin
            chk("hold_out", bo, hold_o);
            chk("hold_err", err, hold_e);
        end
        if (done3 !== 1'b0) begin
            if (q3.size() == 0) chk("spurious_done3", 1, 0);
            else begin
                x = q3.pop_front();
                chk("result3", bo3, x.o);
                chk("error3", err3, x.e);
                hold_o3 = x.o;
                hold_e3 = x.e;
            end
        end else begin
            chk("hold_out3", bo3, hold_o3);
            chk("hold_err3", err3, hold_e3);
        end
    end

    // One conversion on the 2-digit instance. Starts in the cycle after the
    // call (cycle 0), checks busy through done and the done latency.
    task automatic run(input logic [7:0] v, input bit noise);
        logic [WL-1:0] eo;
        logic          ee;
        int            lat;
        int            cyc;
        bit            seen;
        model({4'h0, v}, 2, eo, ee);
        lat = (v[3:0] > 4'd9 || v[7:4] > 4'd9) ? 1 : WL + 1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        start = 1'b1;
        bcd   = v;
        q.push_back('{e: ee, o: eo});
        seen = 0;
        cyc  = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            chk("busy", busy, 1);
            if (done === 1'b1) seen = 1;
            if (!seen && noise) begin
                start = 1'($urandom_range(0, 1));
                bcd   = 8'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
        chk("latency", cyc, lat);
    endtask

    task automatic conv3(input logic [11:0] v);
        logic [WL-1:0] eo;
        logic          ee;
        bit            seen;
        model(v, 3, eo, ee);
        @(negedge clk);
        start3 = 1'b1;
        bcd3   = v;
        q3.push_back('{e: ee, o: eo});
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            start3 = 1'b0;
            if (done3 === 1'b1) seen = 1;
        end
        chk("done3_seen", seen, 1);
    endtask

    initial begin
        logic [WL-1:0] mo;
        logic          me;

        reset  = 1'b1;
        start  = 1'b0;
        start3 = 1'b0;
        bcd    = '0;
        bcd3   = '0;

        // Model anchors.
        model(12'h099, 2, mo, me); chk("pin_99_o", mo, 99);  chk("pin_99_e", me, 0);
        model(12'h02A, 2, mo, me); chk("pin_2A_o", mo, 0);   chk("pin_2A_e", me, 1);
        model(12'h128, 3, mo, me); chk("pin_128_o", mo, 0);  chk("pin_128_e", me, 1);
        model(12'h127, 3, mo, me); chk("pin_127_o", mo, 127); chk("pin_127_e", me, 0);
        model(12'h150, 3, mo, me); chk("pin_150_o", mo, 22); chk("pin_150_e", me, 1);

        repeat (3) @(negedge clk);
        chk("rst_out", bo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy3", busy3, 0);
        reset = 1'b0;

        // Full-scale two-digit value.
        run(8'h99, 0);
        chk("lit_99", bo, 99);
        chk("lit_99_err", err, 0);

        // Back-to-back.
        run(8'h00, 0);
        run(8'h01, 0);
        run(8'h10, 0);
        chk("lit_10", bo, 10);

        // Invalid digit, then a valid value.
        run(8'h2A, 0);
        chk("lit_2A_out", bo, 0);
        chk("lit_2A_err", err, 1);
        run(8'h42, 0);
        chk("lit_42", bo, 42);
        chk("lit_42_err", err, 0);

        // Three digits into seven bits.
        conv3(12'h128);
        chk("lit_128_out", bo3, 0);
        chk("lit_128_err", err3, 1);
        conv3(12'h127);
        chk("lit_127_out", bo3, 127);
        chk("lit_127_err", err3, 0);
        conv3(12'h150);
        conv3(12'hA00);
        conv3(12'h000);

        // Reset in cycle 4 of a conversion aborts it.
        @(negedge clk);
        start = 1'b1;
        bcd   = 8'h57;
        q.push_back('{e: 1'b0, o: WL'(57)});
        repeat (4) @(negedge clk) start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_out", bo, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        repeat (10) @(negedge clk) chk("abort_no_done", done, 0);
        run(8'h57, 0);
        chk("lit_57", bo, 57);

        // Inputs toggled while shifting must not disturb the result.
        run(8'h63, 1);
        chk("lit_63", bo, 63);

        // Sweep of all valid two-digit codes.
        for (int t = 0; t < 10; t++) begin
            for (int u = 0; u < 10; u++) begin
                run({4'(t), 4'(u)}, bit'(u % 2));
            end
        end

        repeat (3) @(negedge clk);
        chk("q_empty", q.size(), 0);
        chk("q3_empty", q3.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

endmodule
